// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
//
// Shared definitions for the interrupt vector controller:
//   - LVL_W / NLVL : width of a priority level and number of levels
//   - state_t      : handshake FSM states (IDLE, PEND)
//   - msb_t        : result of msb8, the highest set bit of an 8-bit mask
//   - msb8()       : priority search used for the in-service register
// -----------------------------------------------------------------------------
package irq_pkg;

    localparam int LVL_W = 3;
    localparam int NLVL  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // valid is 0 when the mask is all zeros; idx is then 0 and meaningless.
    typedef struct packed {
        logic             valid;
        logic [LVL_W-1:0] idx;
    } msb_t;

    // Index of the highest set bit; later (higher) bits overwrite earlier ones.
    function automatic msb_t msb8(input logic [NLVL-1:0] mask);
        msb_t res;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int i = 0; i < NLVL; i++) begin
            if (mask[i]) begin
                res.valid = 1'b1;
                res.idx   = LVL_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/req_filter.sv
// -----------------------------------------------------------------------------
// req_filter
//
// Two-stage sampler on the priority encoder outputs. A request only becomes a
// candidate once two consecutive samples agree and both show a request, which
// rejects single-cycle glitches and code changes in flight.
//
// Ports:
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset (samples -> "no request")
//   enc_a      in  3  active-low encoded level from the encoder
//   enc_gs_n   in  1  low when any request is active
//   cand_valid out 1  both samples agree and carry a request
//   cand_lvl   out 3  candidate level (7 = highest priority)
// -----------------------------------------------------------------------------
module req_filter
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [LVL_W-1:0] enc_a,
    input  logic             enc_gs_n,
    output logic             cand_valid,
    output logic [LVL_W-1:0] cand_lvl
);

    // {gs_n, code}; the reset value encodes "no request".
    localparam logic [LVL_W:0] SAMP_IDLE = {1'b1, {LVL_W{1'b1}}};

    logic [LVL_W:0] samp_p0;
    logic [LVL_W:0] samp_p1;

    // Stage p0: first sample, stage p1: second sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_p0 <= SAMP_IDLE;
            samp_p1 <= SAMP_IDLE;
        end else begin
            samp_p0 <= {enc_gs_n, enc_a};
            samp_p1 <= samp_p0;
        end
    end

    // Comparing the full {gs_n, code} word also covers a gs_n mismatch.
    assign cand_valid = ~samp_p0[LVL_W] & (samp_p0 == samp_p1);
    assign cand_lvl   = ~samp_p0[LVL_W-1:0];

endmodule

// File: rtl/irq_vector_ctrl.sv
// -----------------------------------------------------------------------------
// irq_vector_ctrl
//
// Registered interrupt controller behind an 8-to-3 active-low priority encoder.
// Filters the encoder output, presents one interrupt at a time with a stable
// vector, runs an irq/ack handshake and tracks nesting in an 8-bit in-service
// register. Only a level strictly above the highest in-service level may be
// raised; eoi retires the highest in-service level.
//
// Parameters:
//   VEC_BASE   upper 5 bits of the delivered vector
//
// Ports:
//   clk       in  1  rising-edge clock
//   rst       in  1  synchronous active-high reset
//   enc_a     in  3  active-low encoded request (level = ~enc_a)
//   enc_gs_n  in  1  low when a request is active
//   ack       in  1  CPU accepts the pending interrupt
//   eoi       in  1  end-of-interrupt pulse
//   irq       out 1  interrupt pending
//   vector    out 8  {VEC_BASE, level}
//   isr       out 8  in-service register
//   busy      out 1  isr is non-zero
// -----------------------------------------------------------------------------
module irq_vector_ctrl
    import irq_pkg::*;
#(
    parameter logic [4:0] VEC_BASE = 5'b00000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] enc_a,
    input  logic       enc_gs_n,
    input  logic       ack,
    input  logic       eoi,
    output logic       irq,
    output logic [7:0] vector,
    output logic [7:0] isr,
    output logic       busy
);

    logic             cand_valid;
    logic [LVL_W-1:0] cand_lvl;

    state_t           state_q;
    state_t           state_nxt;
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_nxt;
    logic             irq_q;
    logic             irq_nxt;
    logic [NLVL-1:0]  isr_q;
    logic [NLVL-1:0]  isr_nxt;
    logic             busy_q;

    msb_t             isr_top;
    logic             eligible;

    req_filter u_filter (
        .clk        (clk),
        .rst        (rst),
        .enc_a      (enc_a),
        .enc_gs_n   (enc_gs_n),
        .cand_valid (cand_valid),
        .cand_lvl   (cand_lvl)
    );

    // Nesting rule: a candidate must outrank everything already in service.
    assign isr_top  = msb8(isr_q);
    assign eligible = cand_valid & (~isr_top.valid | (cand_lvl > isr_top.idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        lvl_nxt   = lvl_q;
        irq_nxt   = irq_q;
        isr_nxt   = isr_q;

        // eoi acts on the old isr first; an ack in the same cycle then sets
        // its own bit on top of that, so both land on the same edge.
        if (eoi && isr_top.valid) begin
            isr_nxt[isr_top.idx] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_nxt = PEND;
                    lvl_nxt   = cand_lvl;
                    irq_nxt   = 1'b1;
                end
            end
            PEND: begin
                if (ack) begin
                    // Commit the latched level even if the request is gone.
                    isr_nxt[lvl_q] = 1'b1;
                    irq_nxt        = 1'b0;
                    state_nxt      = IDLE;
                end else if (eligible && (cand_lvl > lvl_q)) begin
                    lvl_nxt = cand_lvl;
                end
            end
            default: begin
                state_nxt = IDLE;
                irq_nxt   = 1'b0;
            end
        endcase
    end

    // Output register stage: every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q  <= '0;
            irq_q  <= 1'b0;
            isr_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_nxt;
            irq_q  <= irq_nxt;
            isr_q  <= isr_nxt;
            busy_q <= |isr_nxt;
        end
    end

    assign irq    = irq_q;
    assign vector = {VEC_BASE, lvl_q};
    assign isr    = isr_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_vector_ctrl
//
// Self-checking bench. A small cycle model predicts the outputs for every
// driven cycle; the prediction is queued when the stimulus is applied and
// popped for comparison after the edge. Directed checks against fixed values
// cover each scenario's key points.
// -----------------------------------------------------------------------------
module tb_irq_vector_ctrl;

    localparam logic [4:0] VB = 5'b10100;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] enc_a;
    logic       enc_gs_n;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [7:0] vector;
    logic [7:0] isr;
    logic       busy;

    irq_vector_ctrl #(.VEC_BASE(VB)) dut (
        .clk      (clk),
        .rst      (rst),
        .enc_a    (enc_a),
        .enc_gs_n (enc_gs_n),
        .ack      (ack),
        .eoi      (eoi),
        .irq      (irq),
        .vector   (vector),
        .isr      (isr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irq;
        logic [7:0] vec;
        logic [7:0] isr;
        logic       busy;
    } exp_t;

    exp_t  sb[$];
    int    n_chk = 0;
    int    n_err = 0;
    string phase = "init";

    // Reference model state.
    logic [3:0] m_s1 = 4'hF;
    logic [3:0] m_s2 = 4'hF;
    logic       m_pend = 1'b0;
    logic [2:0] m_lvl = 3'd0;
    logic [7:0] m_isr = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
        end
    endtask

    // Advance the model by one edge and queue the predicted outputs.
    task automatic model_step(input logic g, input logic [2:0] a, input logic k,
                              input logic e, input logic r);
        logic       cv;
        logic [2:0] lv;
        int         top;
        logic       elig;
        logic [7:0] n_isr;
        exp_t       x;
        cv  = (m_s1[3] == 1'b0) && (m_s2[3] == 1'b0) && (m_s1[2:0] == m_s2[2:0]);
        lv  = ~m_s1[2:0];
        top = -1;
        for (int i = 0; i < 8; i++) if (m_isr[i]) top = i;
        elig  = cv && (int'(lv) > top);
        n_isr = m_isr;
        if (e && top >= 0) n_isr[top] = 1'b0;
        if (r) begin
            m_pend = 1'b0; m_lvl = 3'd0; n_isr = 8'h00;
            m_s1 = 4'hF; m_s2 = 4'hF;
        end else begin
            if (m_pend) begin
                if (k) begin
                    n_isr[m_lvl] = 1'b1;
                    m_pend = 1'b0;
                end else if (elig && lv > m_lvl) begin
                    m_lvl = lv;
                end
            end else if (elig) begin
                m_pend = 1'b1;
                m_lvl  = lv;
            end
            m_s2 = m_s1;
            m_s1 = {g, a};
        end
        m_isr  = n_isr;
        x.irq  = m_pend;
        x.vec  = {VB, m_lvl};
        x.isr  = m_isr;
        x.busy = (m_isr != 8'h00);
        sb.push_back(x);
    endtask

    task automatic cyc(input logic g, input logic [2:0] a, input logic k,
                       input logic e, input logic r);
        exp_t x;
        enc_gs_n = g; enc_a = a; ack = k; eoi = e; rst = r;
        model_step(g, a, k, e, r);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL %s/sb: scoreboard empty", phase);
        end else begin
            x = sb.pop_front();
            check("irq",    {7'd0, irq},  {7'd0, x.irq});
            check("vector", vector,       x.vec);
            check("isr",    isr,          x.isr);
            check("busy",   {7'd0, busy}, {7'd0, x.busy});
        end
    endtask

    task automatic hold(input logic g, input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) cyc(g, a, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input logic ei, input logic [7:0] ev, input logic [7:0] es);
        check("d_irq",    {7'd0, irq},  {7'd0, ei});
        check("d_vector", vector,       ev);
        check("d_isr",    isr,          es);
        check("d_busy",   {7'd0, busy}, {7'd0, es != 8'h00});
    endtask

    initial begin
        rst = 1'b1; enc_gs_n = 1'b1; enc_a = 3'b111; ack = 1'b0; eoi = 1'b0;

        phase = "reset";
        cyc(1'b1, 3'b111, 1'b0, 1'b0, 1'b1);
        expect_out(1'b0, 8'hA0, 8'h00);

        phase = "ack_idle";
        cyc(1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
        expect_out(1'b0, 8'hA0, 8'h00);

        phase = "basic";
        hold(1'b0, 3'b101, 2);
        check("not_yet", {7'd0, irq}, 8'h00);
        hold(1'b0, 3'b101, 1);
        expect_out(1'b1, 8'hA2, 8'h00);
        cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        expect_out(1'b0, 8'hA2, 8'h04);
        hold(1'b0, 3'b101, 2);
        check("no_retrig", {7'd0, irq}, 8'h00);
        cyc(1'b0, 3'b101, 1'b0, 1'b1, 1'b0);
        expect_out(1'b0, 8'hA2, 8'h00);
        hold(1'b0, 3'b101, 1);
        expect_out(1'b1, 8'hA2, 8'h00);
        cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3'b111, 1'b0, 1'b1, 1'b0);
        expect_out(1'b0, 8'hA2, 8'h00);
        hold(1'b1, 3'b111, 2);

        phase = "glitch";
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, (i % 2) ? 3'b111 : 3'b000, 1'b0, 1'b0, 1'b0);
            check("quiet", {7'd0, irq}, 8'h00);
        end
        hold(1'b0, 3'b110, 2);
        check("quiet2", {7'd0, irq}, 8'h00);
        hold(1'b0, 3'b110, 1);
        expect_out(1'b1, 8'hA1, 8'h00);
        cyc(1'b0, 3'b110, 1'b1, 1'b0, 1'b0);
        expect_out(1'b0, 8'hA1, 8'h02);
        cyc(1'b1, 3'b111, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 3'b111, 2);

        phase = "preempt";
        hold(1'b0, 3'b101, 3);
        expect_out(1'b1, 8'hA2, 8'h00);
        hold(1'b0, 3'b000, 2);
        expect_out(1'b1, 8'hA2, 8'h00);
        hold(1'b0, 3'b000, 1);
        expect_out(1'b1, 8'hA7, 8'h00);
        cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        expect_out(1'b0, 8'hA7, 8'h80);
        cyc(1'b1, 3'b111, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 3'b111, 2);

        phase = "nesting";
        hold(1'b0, 3'b100, 3);
        expect_out(1'b1, 8'hA3, 8'h00);
        cyc(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
        expect_out(1'b0, 8'hA3, 8'h08);
        for (int i = 0; i < 4; i++) begin
            hold(1'b0, 3'b110, 1);
            check("blocked", {7'd0, irq}, 8'h00);
        end
        hold(1'b0, 3'b010, 3);
        expect_out(1'b1, 8'hA5, 8'h08);
        cyc(1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
        expect_out(1'b0, 8'hA5, 8'h28);
        cyc(1'b1, 3'b111, 1'b0, 1'b1, 1'b0);
        expect_out(1'b0, 8'hA5, 8'h08);
        cyc(1'b1, 3'b111, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 3'b111, 2);

        phase = "eoi_ack";
        hold(1'b0, 3'b011, 3);
        cyc(1'b0, 3'b011, 1'b1, 1'b0, 1'b0);
        expect_out(1'b0, 8'hA4, 8'h10);
        hold(1'b0, 3'b001, 3);
        expect_out(1'b1, 8'hA6, 8'h10);
        cyc(1'b0, 3'b001, 1'b1, 1'b1, 1'b0);
        expect_out(1'b0, 8'hA6, 8'h40);
        cyc(1'b1, 3'b111, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 3'b111, 2);

        phase = "reset_pend";
        hold(1'b0, 3'b111, 3);
        expect_out(1'b1, 8'hA0, 8'h00);
        cyc(1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
        hold(1'b0, 3'b000, 3);
        cyc(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        expect_out(1'b0, 8'hA7, 8'h81);
        cyc(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        expect_out(1'b0, 8'hA7, 8'h01);
        hold(1'b0, 3'b000, 1);
        expect_out(1'b1, 8'hA7, 8'h01);
        cyc(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        expect_out(1'b0, 8'hA0, 8'h00);
        hold(1'b0, 3'b000, 2);
        check("post_rst", {7'd0, irq}, 8'h00);
        hold(1'b0, 3'b000, 1);
        expect_out(1'b1, 8'hA7, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
